// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO: any depth, standard/FWFT read, programmable flags, flush.
// Optional per-entry even parity with parity_err output when FIFO_PARITY_EN is defined.
module fifo_sync_prog #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    input  logic [LVL_W-1:0]      prog_full_thresh,
    input  logic [LVL_W-1:0]      prog_empty_thresh,
    output logic                  prog_full,
    output logic                  prog_empty,
`ifdef FIFO_PARITY_EN
    output logic                  parity_err,
`endif
    output logic [LVL_W-1:0]      level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef FIFO_PARITY_EN
    localparam int MEM_W = FIFO_WIDTH + 1;
`else
    localparam int MEM_W = FIFO_WIDTH;
`endif

    logic [MEM_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  valid_q, valid_d;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      head_word;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty       = (level_q == '0);
    assign full        = (level_q == LVL_W'(FIFO_DEPTH));
    assign almostfull  = (level_q == LVL_W'(FIFO_DEPTH - 1));
    assign almostempty = (level_q == LVL_W'(1));
    assign prog_full   = (level_q >= prog_full_thresh);
    assign prog_empty  = (level_q <= prog_empty_thresh);
    assign level       = level_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    assign head_word = mem_q[rd_ptr_q];
`ifdef FIFO_PARITY_EN
    assign wr_word = {^data_in, data_in};
`else
    assign wr_word = data_in;
`endif

    always_comb begin
        rd_acc = rd_en && !empty && !flush && !rst;
        wr_acc = wr_en && !flush && !rst && (!full || rd_acc);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        wr_ack_d    = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        valid_d     = 1'b0;
        dout_d      = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ack_d    = wr_acc;
            overflow_d  = wr_en && !wr_acc;
            underflow_d = rd_en && !rd_acc;
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                valid_d  = 1'b1;
                dout_d   = head_word[FIFO_WIDTH-1:0];
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

`ifdef FIFO_PARITY_EN
    logic head_perr;
    logic par_err_q, par_err_d;

    assign head_perr = (^head_word[FIFO_WIDTH-1:0]) != head_word[FIFO_WIDTH];

    always_comb begin
        par_err_d = 1'b0;
        if (!flush) begin
            par_err_d = rd_acc && head_perr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    generate
        if (FWFT != 0) begin : g_fwft
            assign valid    = !empty;
            assign data_out = empty ? '0 : head_word[FIFO_WIDTH-1:0];
`ifdef FIFO_PARITY_EN
            assign parity_err = !empty && head_perr;
`endif
        end else begin : g_std
            assign valid    = valid_q;
            assign data_out = dout_q;
`ifdef FIFO_PARITY_EN
            assign parity_err = par_err_q;
`endif
        end
    endgenerate

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
Parametrised single-clock FIFO, the successor to the team's fixed-mode FIFO. It adds:
- arbitrary (non-power-of-2) depth;
- selectable standard or first-word-fall-through (FWFT) read mode;
- run-time programmable full/empty thresholds;
- a fill-level output;
- a synchronous flush.

It sits between producer and consumer datapaths that need back-pressure flags.

Parameters:
FIFO_WIDTH, 8, data word width in bits (>=1)
FIFO_DEPTH, 16, number of entries (>=2, any integer)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
LVL_W, $clog2(FIFO_DEPTH+1), width of level and threshold ports (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of FIFO contents
wr_en  input  1  write request
data_in  input  FIFO_WIDTH  write data
rd_en  input  1  read request (FWFT: pop head word)
data_out  output  FIFO_WIDTH  read data
valid  output  1  data_out holds a valid word
wr_ack  output  1  previous-cycle write accepted
overflow  output  1  previous-cycle write rejected
underflow  output  1  previous-cycle read rejected
full  output  1  level == FIFO_DEPTH
empty  output  1  level == 0
almostfull  output  1  level == FIFO_DEPTH-1
almostempty  output  1  level == 1
prog_full_thresh  input  LVL_W  programmable full threshold
prog_empty_thresh  input  LVL_W  programmable empty threshold
prog_full  output  1  level >= prog_full_thresh
prog_empty  output  1  level <= prog_empty_thresh
level  output  LVL_W  current number of stored words

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - level = 0; wr_ptr = rd_ptr = 0.
  - wr_ack, overflow, underflow, valid = 0; data_out = 0.
  - Memory is not cleared.
  - Flags follow level, so after reset: empty = 1, full = 0, almostempty = 0, almostfull = 0. prog_empty/prog_full follow their thresholds.
- Pointers: range 0..FIFO_DEPTH-1. Wrap explicitly from FIFO_DEPTH-1 to 0; never rely on binary overflow.
- level is the only occupancy source. All flags are combinational from level and the threshold inputs.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc).
  - Accepted: mem[wr_ptr] <= data_in, wr_ptr advances, wr_ack = 1 next cycle.
  - Rejected: overflow = 1 next cycle, wr_ack = 0.
  - Both are single-cycle pulses.
- Read acceptance: rd_acc = rd_en && !empty.
  - Rejected: underflow = 1 next cycle, single-cycle pulse.
- Simultaneous read and write:
  - When full: both accepted, level unchanged.
  - When empty: write accepted, read rejected (underflow = 1), level +1.
- level update: +1 on write only, -1 on read only, unchanged on both or neither.
- Standard mode (FWFT = 0):
  - On rd_acc, data_out <= mem[rd_ptr] and valid = 1 the next cycle.
  - valid = 0 in cycles with no accepted read.
  - data_out holds its last value when no read is accepted.
- FWFT mode (FWFT = 1):
  - data_out = mem[rd_ptr] whenever !empty; valid = !empty.
  - rd_en pops the head. The next head appears the cycle after the pop.
  - A word written into an empty FIFO appears on data_out with valid = 1 one cycle after the write.
- flush:
  - level and pointers go to 0 next cycle; wr_ack, overflow and underflow are cleared; valid = 0.
  - flush takes priority over wr_en and rd_en in the same cycle; neither is accepted and no overflow/underflow is reported.
- rst takes priority over flush.
- Thresholds:
  - Sampled live, no registering.
  - prog_full_thresh = 0 forces prog_full = 1.
  - prog_empty_thresh >= FIFO_DEPTH forces prog_empty = 1.
- Reset mid-operation: all stored words are discarded. No write or read is accepted in the reset cycle.

Optional Feature:
FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from data_in on write.
  - On every accepted read (FWFT: whenever valid), parity is recomputed over the output word.
  - Extra output parity_err (1 bit) is asserted when the recomputed parity mismatches the stored bit. Timing matches data_out/valid; reset value 0.
  - Memory becomes FIFO_WIDTH+1 bits wide.
- Undefined: no parity storage and no parity_err port; memory is FIFO_WIDTH bits wide.

Test Plan:
All scenarios use FIFO_WIDTH = 8, FIFO_DEPTH = 12, FWFT = 0 unless stated.
1. Fill then drain: write 0x01..0x0C over 12 cycles -> wr_ack on each, level = 12, full = 1, almostfull seen at level = 11; 13th write -> overflow = 1, wr_ack = 0; 12 reads -> data_out 0x01..0x0C in order with valid, then empty = 1; one more read -> underflow = 1.
2. Non-power-of-2 wrap: 20 interleaved write/read pairs starting with 5 words stored -> pointers wrap 11 -> 0, level stays 5, data order preserved.
3. Simultaneous access: at level 12, wr_en = rd_en = 1 with data 0xAA -> no overflow, level stays 12, 0xAA read last. At level 0, both asserted -> wr_ack = 1, underflow = 1, level = 1.
4. Programmable flags: prog_full_thresh = 9, prog_empty_thresh = 2; write 9 words -> prog_empty falls at level 3, prog_full rises at level 9; change prog_full_thresh to 10 -> prog_full falls the same cycle.
5. FWFT = 1: write 0x5A into empty FIFO -> next cycle data_out = 0x5A, valid = 1 with no rd_en; rd_en for one cycle -> valid = 0, empty = 1.
6. Flush and reset: level 7, flush together with wr_en and rd_en -> next cycle level = 0, empty = 1, no wr_ack/underflow. Assert rst mid-burst -> next cycle all outputs at reset values.
